// File: rtl/alu_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_sequencer_if
// Groups every non-clock/reset signal of alu_sequencer into one bundle.
//   Decoder handshake : op_valid, op_ready, opcode, imm
//   Register file     : reg_raddr, reg_rdata, hl
//   Memory read port  : mem_req, mem_addr, mem_ack, mem_rdata
//   ALU side          : alu_op1, alu_op2, alu_cmd, alu_result, alu_z/h/c
//   Status            : a_q, f_q, done, err, state_dbg (FSM state for checkers)
//   Optional (ALU_SEQ_A_WRITE_EN): a_we, a_wdata
// Handshake: a transfer happens on a rising edge where op_valid && op_ready;
// op_ready depends only on sequencer state, never on op_valid.
// modport slave  : the sequencer itself.
// modport master : the surrounding environment (decoder, regfile, bus, ALU).
// ----------------------------------------------------------------------------
interface alu_sequencer_if;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  opcode;
  logic [7:0]  imm;
  logic [2:0]  reg_raddr;
  logic [7:0]  reg_rdata;
  logic [15:0] hl;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [7:0]  alu_op1;
  logic [7:0]  alu_op2;
  logic [2:0]  alu_cmd;
  logic [7:0]  alu_result;
  logic        alu_z;
  logic        alu_h;
  logic        alu_c;
  logic [7:0]  a_q;
  logic [7:0]  f_q;
  logic        done;
  logic        err;
  logic [1:0]  state_dbg;
`ifdef ALU_SEQ_A_WRITE_EN
  logic        a_we;
  logic [7:0]  a_wdata;
`endif

  modport slave (
`ifdef ALU_SEQ_A_WRITE_EN
    input  a_we, a_wdata,
`endif
    input  op_valid, opcode, imm, reg_rdata, hl, mem_ack, mem_rdata,
           alu_result, alu_z, alu_h, alu_c,
    output op_ready, reg_raddr, mem_req, mem_addr, alu_op1, alu_op2, alu_cmd,
           a_q, f_q, done, err, state_dbg
  );

  modport master (
`ifdef ALU_SEQ_A_WRITE_EN
    output a_we, a_wdata,
`endif
    output op_valid, opcode, imm, reg_rdata, hl, mem_ack, mem_rdata,
           alu_result, alu_z, alu_h, alu_c,
    input  op_ready, reg_raddr, mem_req, mem_addr, alu_op1, alu_op2, alu_cmd,
           a_q, f_q, done, err, state_dbg
  );
endinterface

// File: rtl/alu_sequencer.sv
// ----------------------------------------------------------------------------
// alu_sequencer
// Control stage in front of the 8-bit GB ALU. Accepts a decoded ALU opcode
// (0x80-0xBF register/(HL) source, 0xC6-0xFE immediate), gathers the operand,
// drives the ALU, then writes the result into A and the flags into F.
// Ports:
//   clk    - clock, all state on the rising edge
//   rst_n  - synchronous active-low reset
//   bus    - alu_sequencer_if.slave (handshake, regfile, memory, ALU, status)
// Parameters: A_RESET, F_RESET (post-boot A/F), MEM_TIMEOUT (0 = wait forever).
// Optional feature macro ALU_SEQ_A_WRITE_EN: a_we/a_wdata load A while IDLE.
// FSM: IDLE -> [FETCH] -> EXEC -> WB -> IDLE, FETCH only for the (HL) source.
// ----------------------------------------------------------------------------
module alu_sequencer #(
  parameter logic [7:0] A_RESET     = 8'h01,
  parameter logic [7:0] F_RESET     = 8'hB0,
  parameter int         MEM_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_e;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [2:0] CMD_SUB = 3'b010;
  localparam logic [2:0] CMD_SBC = 3'b011;
  localparam logic [2:0] CMD_AND = 3'b100;
  localparam logic [2:0] CMD_CP  = 3'b111;

  state_e          state_q, state_d;
  logic [7:0]      acc_q, acc_d;
  logic [7:0]      flg_q, flg_d;
  logic [2:0]      cmd_q, cmd_d;
  logic [7:0]      opnd_q, opnd_d;
  logic [7:0]      res_q, res_d;
  logic [3:0]      rflg_q, rflg_d;   // {Z,N,H,C} captured in EXEC
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [7:0]      hold_op1_q, hold_op1_d;
  logic [7:0]      hold_op2_q, hold_op2_d;
  logic [2:0]      hold_cmd_q, hold_cmd_d;

  // Opcode decode
  logic is_alu_reg, is_imm, src_hl, src_a;
  assign is_alu_reg = (bus.opcode[7:6] == 2'b10);
  assign is_imm     = (bus.opcode[7:6] == 2'b11) && (bus.opcode[2:0] == 3'b110);
  assign src_hl     = is_alu_reg && (bus.opcode[2:0] == 3'b110);
  assign src_a      = is_alu_reg && (bus.opcode[2:0] == 3'b111);

  // Flag shaping for the command held in cmd_q
  logic logic_op, flag_n, flag_h, flag_c;
  assign logic_op = cmd_q[2] && (cmd_q != CMD_CP);   // AND / XOR / OR
  assign flag_n   = (cmd_q == CMD_SUB) || (cmd_q == CMD_SBC) || (cmd_q == CMD_CP);
  assign flag_h   = (cmd_q == CMD_AND) ? 1'b1 : (logic_op ? 1'b0 : bus.alu_h);
  assign flag_c   = logic_op ? 1'b0 : bus.alu_c;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    flg_d      = flg_q;
    cmd_d      = cmd_q;
    opnd_d     = opnd_q;
    res_d      = res_q;
    rflg_d     = rflg_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    hold_op1_d = hold_op1_q;
    hold_op2_d = hold_op2_q;
    hold_cmd_d = hold_cmd_q;

    case (state_q)
      S_IDLE: begin
`ifdef ALU_SEQ_A_WRITE_EN
        // opnd_d below still sees the old acc_q, so an accepted op with
        // src=A uses A from before this load.
        if (bus.a_we) acc_d = bus.a_wdata;
`endif
        if (bus.op_valid) begin
          cmd_d = bus.opcode[5:3];
          if (is_imm) begin
            opnd_d  = bus.imm;
            state_d = S_EXEC;
          end else if (src_hl) begin
            cnt_d   = '0;
            state_d = S_FETCH;
          end else if (src_a) begin
            opnd_d  = acc_q;
            state_d = S_EXEC;
          end else if (is_alu_reg) begin
            opnd_d  = bus.reg_rdata;
            state_d = S_EXEC;
          end else begin
            // Illegal opcode: consumed, reported, no architectural change
            err_d = 1'b1;
          end
        end
      end

      S_FETCH: begin
        if (bus.mem_ack) begin
          opnd_d  = bus.mem_rdata;
          cnt_d   = '0;
          state_d = S_EXEC;
        end else if ((MEM_TIMEOUT != 0) && (cnt_q == CW'(MEM_TIMEOUT - 1))) begin
          // This non-ack cycle brings the count to MEM_TIMEOUT
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_EXEC: begin
        res_d      = bus.alu_result;
        rflg_d     = {bus.alu_z, flag_n, flag_h, flag_c};
        hold_op1_d = acc_q;
        hold_op2_d = opnd_q;
        hold_cmd_d = cmd_q;
        state_d    = S_WB;
      end

      S_WB: begin
        if (cmd_q != CMD_CP) acc_d = res_q;
        flg_d   = {rflg_q, 4'b0000};
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= A_RESET;
      flg_q      <= F_RESET;
      cmd_q      <= 3'b000;
      opnd_q     <= 8'h00;
      res_q      <= 8'h00;
      rflg_q     <= 4'h0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_op1_q <= 8'h00;
      hold_op2_q <= 8'h00;
      hold_cmd_q <= 3'b000;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      flg_q      <= flg_d;
      cmd_q      <= cmd_d;
      opnd_q     <= opnd_d;
      res_q      <= res_d;
      rflg_q     <= rflg_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hold_op1_q <= hold_op1_d;
      hold_op2_q <= hold_op2_d;
      hold_cmd_q <= hold_cmd_d;
    end
  end

  assign bus.op_ready  = (state_q == S_IDLE);
  assign bus.reg_raddr = (state_q == S_IDLE) ? bus.opcode[2:0] : 3'b000;
  assign bus.mem_req   = (state_q == S_FETCH);
  assign bus.mem_addr  = (state_q == S_FETCH) ? bus.hl : 16'h0000;
  // Outside EXEC the ALU inputs replay the last EXEC values
  assign bus.alu_op1   = (state_q == S_EXEC) ? acc_q  : hold_op1_q;
  assign bus.alu_op2   = (state_q == S_EXEC) ? opnd_q : hold_op2_q;
  assign bus.alu_cmd   = (state_q == S_EXEC) ? cmd_q  : hold_cmd_q;
  assign bus.a_q       = acc_q;
  assign bus.f_q       = flg_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.state_dbg = state_q;

endmodule
